// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural Z/N/V flags, illegal-opcode pulse
// and a saturating overflow-event counter; outputs double as the EX/MEM forwarding source.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovfl,
  input  logic [4:0]        alu_ctrl,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              reg_wr_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              stall,
  input  logic              flush,
  output logic              valid_q,
  output logic              reg_wr_q,
  output logic              mem_rd_q,
  output logic              mem_wr_q,
  output logic [DATA_W-1:0] result_q,
  output logic [RD_W-1:0]   rd_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  ovfl_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_accept;
  logic w_kill;
  logic w_arith;
  logic w_logic;
  logic w_byte;
  logic w_legal;

  logic              r_valid;
  logic              r_reg_wr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [DATA_W-1:0] r_result;
  logic [RD_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_store_data;
  logic              r_z;
  logic              r_n;
  logic              r_v;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  // Flush wins over stall; an empty EX slot without stall also becomes a bubble.
  assign w_accept = valid_in & ~stall & ~flush;
  assign w_kill   = flush | (~stall & ~valid_in);

  // Opcode classes that decide which flags an instruction writes.
  assign w_arith = (alu_ctrl <= 5'd1);
  assign w_logic = (alu_ctrl >= 5'd2) && (alu_ctrl <= 5'd6);
  assign w_byte  = (alu_ctrl == 5'd8) || (alu_ctrl == 5'd9);
  assign w_legal = w_arith | w_logic | w_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_store_data <= '0;
      r_z          <= 1'b0;
      r_n          <= 1'b0;
      r_v          <= 1'b0;
      r_illegal    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept) begin
        r_valid      <= 1'b1;
        r_reg_wr     <= reg_wr_in;
        r_mem_rd     <= mem_rd_in;
        r_mem_wr     <= mem_wr_in;
        r_result     <= alu_out;
        r_rd         <= rd_in;
        r_store_data <= store_data_in;
        if (w_arith || w_logic) begin
          r_z <= (alu_out == '0);
          r_n <= alu_out[DATA_W-1];
        end
        if (w_arith) begin
          r_v <= alu_ovfl;
        end
        if (w_arith && alu_ovfl && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_kill) begin
        r_valid  <= 1'b0;
        r_reg_wr <= 1'b0;
        r_mem_rd <= 1'b0;
        r_mem_wr <= 1'b0;
      end
    end
  end

  assign valid_q      = r_valid;
  assign reg_wr_q     = r_reg_wr;
  assign mem_rd_q     = r_mem_rd;
  assign mem_wr_q     = r_mem_wr;
  assign result_q     = r_result;
  assign rd_q         = r_rd;
  assign store_data_q = r_store_data;
  assign flag_z       = r_z;
  assign flag_n       = r_n;
  assign flag_v       = r_v;
  assign illegal_op   = r_illegal;
  assign ovfl_count   = r_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, hand-written
// stall/saturation/reset sequences and a randomized run against a behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, valid_in, alu_ovfl, reg_wr_in, mem_rd_in, mem_wr_in, stall, flush;
  logic [15:0] alu_out, store_data_in;
  logic [4:0]  alu_ctrl;
  logic [3:0]  rd_in;
  logic        valid_q, reg_wr_q, mem_rd_q, mem_wr_q, flag_z, flag_n, flag_v, illegal_op;
  logic [15:0] result_q, store_data_q;
  logic [3:0]  rd_q;
  logic [7:0]  ovfl_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .RD_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out), .alu_ovfl(alu_ovfl),
    .alu_ctrl(alu_ctrl), .rd_in(rd_in), .reg_wr_in(reg_wr_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .store_data_in(store_data_in), .stall(stall), .flush(flush),
    .valid_q(valid_q), .reg_wr_q(reg_wr_q), .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q),
    .result_q(result_q), .rd_q(rd_q), .store_data_q(store_data_q), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .illegal_op(illegal_op), .ovfl_count(ovfl_count)
  );

  // Behavioural reference state
  bit          m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_v, m_ill;
  bit   [15:0] m_res, m_sd;
  bit   [3:0]  m_rd;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural rules applied to whatever inputs are present at the edge.
  task automatic model_edge();
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_v, m_ill} = '0;
      m_res = 0; m_sd = 0; m_rd = 0; m_cnt = 0;
    end else if (flush || (!stall && !valid_in)) begin
      {m_valid, m_rw, m_mr, m_mw, m_ill} = '0;
    end else if (stall) begin
      m_ill = 0;
    end else begin
      m_valid = 1; m_rw = reg_wr_in; m_mr = mem_rd_in; m_mw = mem_wr_in;
      m_res = alu_out; m_sd = store_data_in; m_rd = rd_in;
      m_ill = !(alu_ctrl <= 6 || alu_ctrl == 8 || alu_ctrl == 9);
      if (alu_ctrl <= 6) begin
        m_z = (alu_out == 0);
        m_n = (alu_out >= 16'h8000);
      end
      if (alu_ctrl <= 1) begin
        m_v = alu_ovfl;
        if (alu_ovfl) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    check("valid_q", 32'(valid_q), 32'(m_valid));
    check("reg_wr_q", 32'(reg_wr_q), 32'(m_rw));
    check("mem_rd_q", 32'(mem_rd_q), 32'(m_mr));
    check("mem_wr_q", 32'(mem_wr_q), 32'(m_mw));
    check("result_q", 32'(result_q), 32'(m_res));
    check("rd_q", 32'(rd_q), 32'(m_rd));
    check("store_data_q", 32'(store_data_q), 32'(m_sd));
    check("flag_z", 32'(flag_z), 32'(m_z));
    check("flag_n", 32'(flag_n), 32'(m_n));
    check("flag_v", 32'(flag_v), 32'(m_v));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("ovfl_count", 32'(ovfl_count), 32'(m_cnt));
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input bit f, input bit [4:0] c,
                       input bit [15:0] o, input bit ov, input bit [3:0] d, input bit rw,
                       input bit mw, input bit [15:0] sd);
    rst = r; valid_in = v; stall = s; flush = f; alu_ctrl = c; alu_out = o; alu_ovfl = ov;
    rd_in = d; reg_wr_in = rw; mem_rd_in = 1'b0; mem_wr_in = mw; store_data_in = sd;
  endtask

  typedef struct {
    bit        rst, valid, stall, flush;
    bit [4:0]  ctrl;
    bit [15:0] aout;
    bit        ovfl;
    bit [3:0]  rd;
    bit        rw, mw;
    bit [15:0] sd;
    bit        e_valid, e_rw, e_mw;
    bit [15:0] e_res;
    bit [3:0]  e_rd;
    bit        e_z, e_n, e_v, e_ill;
    bit [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // rst valid stall flush ctrl aout ovfl rd rw mw sd | valid rw mw res rd z n v ill cnt
    vecs[0]  = '{1,0,0,0,5'h00,16'h0000,0,0,0,0,16'h0000, 0,0,0,16'h0000,0, 0,0,0,0,0};
    vecs[1]  = '{0,1,0,0,5'h00,16'h0000,0,3,1,0,16'h1111, 1,1,0,16'h0000,3, 1,0,0,0,0};
    vecs[2]  = '{0,1,0,0,5'h01,16'h8000,1,4,1,0,16'h2222, 1,1,0,16'h8000,4, 0,1,1,0,1};
    vecs[3]  = '{0,1,0,0,5'h02,16'h0001,0,5,1,0,16'h3333, 1,1,0,16'h0001,5, 0,0,1,0,1};
    vecs[4]  = '{0,1,1,1,5'h01,16'h0000,1,6,1,1,16'h4444, 0,0,0,16'h0001,5, 0,0,1,0,1};
    vecs[5]  = '{0,1,0,0,5'h07,16'h0000,0,7,1,0,16'h5555, 1,1,0,16'h0000,7, 0,0,1,1,1};
    vecs[6]  = '{0,1,0,0,5'h08,16'h1234,1,8,1,1,16'h6666, 1,1,1,16'h1234,8, 0,0,1,0,1};
    vecs[7]  = '{0,0,0,0,5'h00,16'h0000,1,9,1,1,16'h7777, 0,0,0,16'h1234,8, 0,0,1,0,1};
    vecs[8]  = '{0,1,0,0,5'h03,16'hFFFE,1,9,0,0,16'h8888, 1,0,0,16'hFFFE,9, 0,1,1,0,1};
    vecs[9]  = '{0,1,0,0,5'h1F,16'h0000,0,10,1,0,16'h9999,1,1,0,16'h0000,10,0,1,1,1,1};
    vecs[10] = '{0,1,1,0,5'h00,16'h0000,1,11,1,0,16'hAAAA,1,1,0,16'h0000,10,0,1,1,0,1};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].ctrl,
            vecs[i].aout, vecs[i].ovfl, vecs[i].rd, vecs[i].rw, vecs[i].mw, vecs[i].sd);
      step();
      check($sformatf("v%0d valid_q", i), 32'(valid_q), 32'(vecs[i].e_valid));
      check($sformatf("v%0d reg_wr_q", i), 32'(reg_wr_q), 32'(vecs[i].e_rw));
      check($sformatf("v%0d mem_wr_q", i), 32'(mem_wr_q), 32'(vecs[i].e_mw));
      check($sformatf("v%0d result_q", i), 32'(result_q), 32'(vecs[i].e_res));
      check($sformatf("v%0d rd_q", i), 32'(rd_q), 32'(vecs[i].e_rd));
      check($sformatf("v%0d flag_z", i), 32'(flag_z), 32'(vecs[i].e_z));
      check($sformatf("v%0d flag_n", i), 32'(flag_n), 32'(vecs[i].e_n));
      check($sformatf("v%0d flag_v", i), 32'(flag_v), 32'(vecs[i].e_v));
      check($sformatf("v%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].e_ill));
      check($sformatf("v%0d ovfl_count", i), 32'(ovfl_count), 32'(vecs[i].e_cnt));
    end

    // Accept one op, then three stalled cycles with churning inputs: outputs frozen.
    drive(0, 1, 0, 0, 5'h02, 16'h00F0, 0, 4'd9, 1, 0, 16'hBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 5'h01, 16'($urandom), 1, 4'($urandom), 0, 1, 16'($urandom));
      step();
      check("stall result_q", 32'(result_q), 32'h00F0);
      check("stall rd_q", 32'(rd_q), 32'd9);
      check("stall valid_q", 32'(valid_q), 32'd1);
      check("stall store_data_q", 32'(store_data_q), 32'hBEEF);
      check("stall ovfl_count", 32'(ovfl_count), 32'd1);
      check("stall flag_z", 32'(flag_z), 32'd0);
    end
    drive(0, 1, 0, 0, 5'h00, 16'h0042, 0, 4'd10, 1, 0, 16'h0);
    step();
    check("release result_q", 32'(result_q), 32'h0042);
    check("release rd_q", 32'(rd_q), 32'd10);
    check("release flag_v", 32'(flag_v), 32'd0);
    check_model();

    // Saturation of the overflow counter, then reset mid-stream.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 0, 0, 5'h00, 16'h8001, 1, 4'd1, 1, 0, 16'h0);
      step();
      if (i == 253) check("count 254", 32'(ovfl_count), 32'd254);
      if (i == 254) check("count 255", 32'(ovfl_count), 32'd255);
    end
    check("count saturated", 32'(ovfl_count), 32'd255);
    check_model();
    drive(1, 1, 1, 1, 5'h00, 16'h8001, 1, 4'd1, 1, 1, 16'hFFFF);
    step();
    check("rst ovfl_count", 32'(ovfl_count), 32'd0);
    check("rst valid_q", 32'(valid_q), 32'd0);
    check("rst result_q", 32'(result_q), 32'd0);
    check("rst flag_n", 32'(flag_n), 32'd0);
    check_model();

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit [4:0] c;
      bit [15:0] o;
      c = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 9));
      o = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if (!(c <= 6 || c == 8 || c == 9)) o = 16'h0000;
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, c, o, 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 16'($urandom));
      mem_rd_in = 1'($urandom);
      step();
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register and condition-flag unit directly downstream of the 16-bit CPU ALU. It captures the ALU result, the overflow bit and the instruction's control fields at the end of EX. It holds them for the MEM stage and exposes them as a forwarding source for the ALU operand muxes. It also maintains the architectural Z/N/V flags consumed by branch logic, plus a saturating overflow-event counter.

## Interface
- DATA_W, 16, ALU result and store-data width
- RD_W, 4, destination register index width
- CNT_W, 8, overflow-event counter width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  an instruction is present in EX this cycle
- alu_out  in  DATA_W  ALU result
- alu_ovfl  in  1  ALU signed-overflow flag (only meaningful for ctrl 0/1)
- alu_ctrl  in  5  ALU opcode of the EX instruction
- rd_in  in  RD_W  destination register
- reg_wr_in, mem_rd_in, mem_wr_in  in  1 each  control bits
- store_data_in  in  DATA_W  register value to be stored on mem_wr
- stall  in  1  hold all state
- flush  in  1  kill the EX instruction (branch mispredict)
- valid_q, reg_wr_q, mem_rd_q, mem_wr_q  out  1 each  registered controls
- result_q  out  DATA_W  registered ALU result (also the forwarding data)
- rd_q  out  RD_W  registered destination
- store_data_q  out  DATA_W  registered store data
- flag_z, flag_n, flag_v  out  1 each  architectural flags
- illegal_op  out  1  one-cycle pulse: an accepted instruction had an undefined alu_ctrl
- ovfl_count  out  CNT_W  saturating count of accepted overflowing add/sub

## Operation
- Accept = valid_in & ~stall & ~flush. All updates below occur only on accept unless stated.
- Pipeline capture on accept: result_q←alu_out, rd_q, reg_wr_q, mem_rd_q, mem_wr_q, store_data_q←inputs, valid_q←1.
- Flush with no stall: valid_q←0 and reg_wr_q, mem_rd_q, mem_wr_q←0. Data fields are don't-care but are held.
- Valid_in=0 with no stall and no flush: same as flush (a bubble is inserted).
- Stall with no flush: every register holds, including flags, counter and valid_q.
- Flush has priority over stall. Flush+stall kills the EX instruction; the bubble is inserted and the controls cleared.
- Flag update classes by alu_ctrl:
  - 0x00/0x01 (add/sub): Z←(alu_out==0), N←alu_out[15], V←alu_ovfl.
  - 0x02–0x06 (and/or/xor/shl/sra): Z and N are updated; V holds.
  - 0x08/0x09 (byte insert): no flag change.
  - Any other code: no flag change. result_q captures alu_out, which is 0 for these codes. illegal_op pulses high for one cycle; the instruction still advances.
- ovfl_count increments on accept when alu_ctrl∈{0,1} and alu_ovfl=1. It saturates at 2^CNT_W−1 and never wraps.
- Forwarding: result_q/rd_q/reg_wr_q/valid_q are the EX/MEM forwarding source. No internal combinational path from inputs to outputs.

## Timing
- All outputs are registered. Latency from inputs to outputs is 1 cycle.
- Flags change on the same edge that result_q captures the producing instruction. A branch in EX in the following cycle sees the new flags.
- Reset (synchronous, any cycle, including mid-stall) clears all outputs:
  - valid_q, all control bits, result_q, rd_q and store_data_q go to 0.
  - flag_z=0, flag_n=0, flag_v=0.
  - illegal_op=0 and ovfl_count=0.
- Reset overrides flush, stall and accept.
- illegal_op is never held across a stall; it is 0 in any cycle without an accept on the previous edge.

## Test plan
- Reset, then present add with alu_out=0x0000, ovfl=0, rd=3, reg_wr=1. Next cycle: result_q=0, rd_q=3, valid_q=1, Z=1, N=0, V=0.
- Sub with alu_out=0x8000 and ovfl=1, then an AND with alu_out=0x0001. After the sub: N=1, V=1, ovfl_count=1. After the AND: Z=0, N=0, V still 1.
- Accept an op, then hold stall=1 for 3 cycles with changing inputs. All outputs stay frozen. Releasing stall captures the current inputs one cycle later.
- flush=1 together with stall=1 and valid_in=1 on a sub with ovfl=1. Next cycle: valid_q=0, reg_wr_q=0, mem_wr_q=0, flags unchanged, ovfl_count unchanged.
- alu_ctrl=0x07 with valid_in=1. Next cycle: illegal_op=1 for exactly one cycle, flags unchanged, valid_q=1. Then 0x08 → no flag change and no pulse.
- Feed 300 accepted overflowing adds (CNT_W=8): ovfl_count reaches 255 and stays there. Asserting rst mid-stream zeroes the counter and all outputs on the next edge.
